// File: rtl/ram_access_coordinator.sv
// Arbitrates NUM_CH requesters onto one shared RAM port, one registered
// transaction at a time, with fixed-priority or round-robin selection.
module ram_access_coordinator #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     mode_rr,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        done_rd,
    output logic [NUM_CH-1:0]        done_wr,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_we,
    output logic                     ram_re,
    input  logic [DATA_W-1:0]        ram_rdata
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = 2;

    if (NUM_CH < 2 || NUM_CH > 8) begin : gBadNumCh
        $error("ram_access_coordinator: NUM_CH must be in 2..8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : gBadRdLat
        $error("ram_access_coordinator: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    state_t            nextState;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  scanIdx;
    logic [ADDR_W-1:0] addrLat;
    logic [DATA_W-1:0] wdataLat;
    logic              weLat;
    logic [CNT_W-1:0]  waitCnt;
    logic [NUM_CH-1:0] ownerOneHot;

    assign ownerOneHot = NUM_CH'(1) << owner;

    // Scanning downwards leaves the first match in scan order as the winner.
    always_comb begin
        winner  = '0;
        scanIdx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mode_rr) begin
                scanIdx = IDX_W'((int'(ptr) + k) % NUM_CH);
            end else begin
                scanIdx = IDX_W'(k);
            end
            if (req[scanIdx]) begin
                winner = scanIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        gnt       = '0;
        done_rd   = '0;
        done_wr   = '0;
        busy      = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                gnt       = ownerOneHot;
                busy      = 1'b1;
                ram_addr  = addrLat;
                ram_we    = weLat;
                ram_re    = !weLat;
                ram_wdata = weLat ? wdataLat : '0;
                nextState = weLat ? DONE : WAIT;
            end
            WAIT: begin
                gnt      = ownerOneHot;
                busy     = 1'b1;
                ram_addr = addrLat;
                if (waitCnt == '0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                gnt       = ownerOneHot;
                busy      = 1'b1;
                done_wr   = weLat ? ownerOneHot : '0;
                done_rd   = weLat ? '0 : ownerOneHot;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Transaction latch, wait counter, read capture and round-robin pointer.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ptr      <= '0;
            owner    <= '0;
            addrLat  <= '0;
            wdataLat <= '0;
            weLat    <= 1'b0;
            waitCnt  <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= winner;
                        addrLat  <= addr[int'(winner)*ADDR_W +: ADDR_W];
                        wdataLat <= wdata[int'(winner)*DATA_W +: DATA_W];
                        weLat    <= we[winner];
                    end
                end
                ISSUE: begin
                    waitCnt <= CNT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        rdata <= ram_rdata;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                default: ;
            endcase
            if (nextState == DONE && state != DONE) begin
                ptr <= (owner == IDX_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
            end
        end
    end
endmodule

// File: doc/ram_access_coordinator.md
Name: ram_access_coordinator

Overview:
- Parametrised successor to the fixed three-way RAM steering in the IO coordinator.
- Arbitrates NUM_CH requesters onto the single shared RAM port through a registered transaction FSM. Typical requesters are the file loader, the decompressor, the CNN engine and the host.
- Supports fixed-priority and round-robin arbitration, and a configurable RAM read latency.
- Returns per-channel read-done and write-done handshakes.

Parameters:
- NUM_CH, 4, number of requester channels (legal range 2..8).
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM cycles from read issue until ram_rdata is valid (legal range 1..4).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- mode_rr  in  1  0 = fixed priority (lowest index wins), 1 = round robin.
- req  in  NUM_CH  per-channel access request, level.
- we  in  NUM_CH  per-channel direction, 1 = write, 0 = read.
- addr  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  packed write data, packed the same way.
- gnt  out  NUM_CH  one-hot owner indication.
- done_rd  out  NUM_CH  one-cycle pulse to the owner when its read data is valid.
- done_wr  out  NUM_CH  one-cycle pulse to the owner when its write has been performed.
- rdata  out  DATA_W  registered read data, broadcast to all channels.
- busy  out  1  high whenever the FSM is not in IDLE.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM goes to IDLE; round-robin pointer goes to 0.
  - All outputs go to 0, including gnt, done_*, rdata, busy, ram_*.
  - Reset mid-transaction aborts that transaction silently; no done pulse is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise select a winner and latch into registers: owner index, addr slice, wdata slice, we bit.
  - Set gnt one-hot to the winner and move to ISSUE.
  - mode_rr is sampled only in IDLE.
- Winner selection, fixed priority: lowest-index asserted req.
- Winner selection, round robin:
  - Take the first asserted req scanning ptr, ptr+1, … NUM_CH-1, 0, … ptr-1.
  - ptr advances to (owner+1) mod NUM_CH on entry to DONE; this update happens in both modes.
- ISSUE (exactly 1 cycle):
  - ram_addr = latched address.
  - Write: ram_we = 1, ram_wdata = latched data, next state DONE.
  - Read: ram_re = 1, next state WAIT.
  - Only one strobe is ever asserted, and only in ISSUE.
- WAIT (RD_LAT cycles):
  - A down-counter is loaded with RD_LAT-1 on entry.
  - On the edge that ends the last WAIT cycle, ram_rdata is captured into rdata and the FSM moves to DONE.
  - ram_addr is held stable throughout WAIT.
- DONE (1 cycle):
  - done_wr[owner] or done_rd[owner] is high.
  - gnt is still high during DONE and clears on exit to IDLE.
- rdata holds its value until the next completed read; writes never change rdata.
- Latency, counted from the edge that samples req in IDLE:
  - Write: done_wr is high in cycle 2.
  - Read: done_rd is high in cycle 2+RD_LAT.
  - Back-to-back transactions have one IDLE cycle between them. Throughput: one write per 3 cycles, one read per 3+RD_LAT cycles.
- Handshake rules:
  - A requester keeps req high until it sees its done pulse.
  - The latched transaction always completes, even if req, addr or we change after latching.
  - req still high in the cycle after DONE is treated as a new request.
  - Simultaneous requests are serviced strictly by the arbitration mode; a single channel can never hold the port across two consecutive grants while another channel is requesting in round-robin mode.
- Illegal NUM_CH or RD_LAT values raise an elaboration-time error.

Test Plan:
- Reset mid-read: assert RST low during WAIT -> every output is 0 immediately, no done pulse; after release, a new request is served normally with ptr=0.
- Single write: ch2 requests we=1, addr=16'h0040, wdata=8'hA5 -> ram_we=1 with ram_addr=16'h0040 and ram_wdata=8'hA5 in cycle 1; done_wr[2] pulses in cycle 2; gnt=4'b0100 during cycles 1-2.
- Single read, RD_LAT=3, RAM returning 8'h3C: ch1 reads addr=16'h0100 -> ram_re is high in cycle 1 only; done_rd[1] pulses in cycle 5; rdata=8'h3C.
- Fixed priority: mode_rr=0, req=4'b1011 held -> grant order ch0, ch0, ch0 … ch1 and ch3 are never granted while ch0 keeps requesting.
- Round robin: mode_rr=1, req=4'b1011 held -> grant order ch0, ch1, ch3, ch0, ch1, ch3; exactly one IDLE cycle between the DONE of one grant and the ISSUE of the next.
- Request withdrawn mid-transaction: ch0 drops req and changes addr during ISSUE -> the write still completes to the originally latched address and done_wr[0] pulses; the next IDLE cycle does not grant ch0.
